// File: rtl/spi_pkg.sv
// Shared SPI master definitions: mode and slave-select codes plus mode field helpers.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_I    = 2'b01,
    SEL_II   = 2'b10,
    SEL_III  = 2'b11
  } spi_sel_e;

  function automatic logic cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: toggles sclk on every running cycle and strobes
// the leading, trailing and final edge of each bit period.
module spi_clk_gen #(
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic cpol_i,
  input  logic run_i,
  output logic sclk_o,
  output logic lead_edge_o,
  output logic trail_edge_o,
  output logic last_edge_o
);

  localparam int CNT_W = $clog2(2 * DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2 * DATA_W - 1);

  logic             sclk_q, sclk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      sclk_q <= sclk_d;
      cnt_q  <= cnt_d;
    end
  end

  // A load re-homes sclk to the new idle polarity and restarts the edge count.
  always_comb begin
    sclk_d = sclk_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      sclk_d = cpol_i;
      cnt_d  = {CNT_W{1'b0}};
    end else if (run_i) begin
      sclk_d = ~sclk_q;
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sclk_d = sclk_q;
      cnt_d  = cnt_q;
    end
  end

  assign sclk_o       = sclk_q;
  assign lead_edge_o  = run_i & ~cnt_q[0];
  assign trail_edge_o = run_i & cnt_q[0];
  assign last_edge_o  = run_i & (cnt_q == LAST_CNT);

endmodule

// File: rtl/spi_master.sv
// SPI master: parallel-loads a byte and exchanges it MSB-first with one of
// three slaves in any of the four SPI modes.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [1:0]        Mode,
  input  logic              MISO,
  input  logic [1:0]        Select,
  input  logic              enable,
  input  logic [DATA_W-1:0] inload,
  output logic              sclk,
  output logic [1:0]        Slave_mode,
  output logic              Done,
  output logic              MOSI,
  output logic              Slave_I,
  output logic              Slave_II,
  output logic              Slave_III,
  output logic [DATA_W-1:0] Master_SR
);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic [1:0]        mode_q, mode_d;
  logic              busy_q, busy_d;

  logic run_s, lead_edge_s, trail_edge_s, last_edge_s, active_s;

  assign run_s = enable & ~done_q & ~load;

  spi_clk_gen #(.DATA_W(DATA_W)) u_clk_gen (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .cpol_i       (cpol(Mode)),
    .run_i        (run_s),
    .sclk_o       (sclk),
    .lead_edge_o  (lead_edge_s),
    .trail_edge_o (trail_edge_s),
    .last_edge_o  (last_edge_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q   <= {DATA_W{1'b0}};
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= SPI_MODE0;
      busy_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      mode_q <= mode_d;
      busy_q <= busy_d;
    end
  end

  // CPHA=0 samples on the leading edge; CPHA=1 drives on leading, samples on trailing.
  always_comb begin
    sr_d   = sr_q;
    mosi_d = mosi_q;
    done_d = done_q;
    mode_d = mode_q;
    busy_d = busy_q;
    if (load) begin
      sr_d   = inload;
      mode_d = Mode;
      done_d = 1'b0;
      busy_d = 1'b1;
      if (cpha(Mode)) mosi_d = 1'b0;
      else            mosi_d = mosi_q;
    end else begin
      if (last_edge_s) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        done_d = done_q;
        busy_d = busy_q;
      end
      if (cpha(mode_q)) begin
        if (lead_edge_s)  mosi_d = sr_q[DATA_W-1];
        else              mosi_d = mosi_q;
        if (trail_edge_s) sr_d = {sr_q[DATA_W-2:0], MISO};
        else              sr_d = sr_q;
      end else begin
        mosi_d = mosi_q;
        if (lead_edge_s)  sr_d = {sr_q[DATA_W-2:0], MISO};
        else              sr_d = sr_q;
      end
    end
  end

  // Chip selects stay high from reset until a load arms a transfer.
  assign active_s  = busy_q & enable & ~done_q;
  assign Slave_I   = ~(active_s & (Select == SEL_I));
  assign Slave_II  = ~(active_s & (Select == SEL_II));
  assign Slave_III = ~(active_s & (Select == SEL_III));

  assign MOSI       = cpha(mode_q) ? mosi_q : sr_q[DATA_W-1];
  assign Slave_mode = mode_q;
  assign Done       = done_q;
  assign Master_SR  = sr_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: a driver issues transfers and queues the
// expected outcome; a monitor pops and compares whenever Done rises.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset, load, MISO, enable;
  logic [1:0] Mode, Select;
  logic [7:0] inload;
  logic       sclk, Done, MOSI, Slave_I, Slave_II, Slave_III;
  logic [1:0] Slave_mode;
  logic [7:0] Master_SR;

  logic loopback = 1'b0;
  logic miso_drv = 1'b0;
  assign MISO = loopback ? MOSI : miso_drv;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .load(load), .Mode(Mode), .MISO(MISO),
    .Select(Select), .enable(enable), .inload(inload), .sclk(sclk),
    .Slave_mode(Slave_mode), .Done(Done), .MOSI(MOSI), .Slave_I(Slave_I),
    .Slave_II(Slave_II), .Slave_III(Slave_III), .Master_SR(Master_SR)
  );

  typedef struct {
    logic [7:0] sr;
    logic [1:0] mode;
    int         lat;
    logic [7:0] mosi;
  } exp_t;

  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] mosi_obs = 8'h00;
  logic       done_prev = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] cs_exp(input logic [1:0] sel, input logic active);
    return {~(active && sel == 2'd1), ~(active && sel == 2'd2), ~(active && sel == 2'd3)};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sr"}, Master_SR, 16'h0000);
    chk({tag, "_mosi"}, MOSI, 16'h0000);
    chk({tag, "_sclk"}, sclk, 16'h0000);
    chk({tag, "_done"}, Done, 16'h0000);
    chk({tag, "_mode"}, Slave_mode, 16'h0000);
    chk({tag, "_cs"}, {Slave_I, Slave_II, Slave_III}, 16'h0007);
  endtask

  always @(posedge clk) cyc <= load ? 0 : cyc + 1;

  // Monitor: every rising Done retires the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && Done === 1'b1 && done_prev === 1'b0) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 16'h0001, 16'h0000);
      end else begin
        e = q.pop_front();
        chk("final_sr", Master_SR, e.sr);
        chk("final_slave_mode", Slave_mode, e.mode);
        chk("final_sclk_idle", sclk, e.mode[1]);
        chk("done_latency", cyc, e.lat);
        chk("mosi_sequence", mosi_obs, e.mosi);
      end
    end
    done_prev <= Done;
  end

  // Model: after k shifts the register holds the top 8 bits of {tx, rx} << k.
  task automatic run_xfer(input logic [1:0] md, input logic [7:0] b, input logic [7:0] m_in,
                          input logic loop, input logic [1:0] sel, input int pause_at,
                          input int pause_len, input int abort_at);
    logic [7:0]  m;
    logic [15:0] bm;
    logic        ph;
    int          e, s, pleft;
    m  = loop ? b : m_in;
    ph = md[0];
    load = 1'b1; inload = b; Mode = md; Select = sel;
    enable = 1'($urandom_range(0, 1));
    loopback = loop; miso_drv = 1'b0;
    if (abort_at < 0) q.push_back('{sr: m, mode: md, lat: 16 + pause_len, mosi: b});
    @(negedge clk);
    load = 1'b0;
    Mode = 2'($urandom);
    chk("load_sr", Master_SR, b);
    chk("load_sclk", sclk, md[1]);
    chk("load_done", Done, 16'h0000);
    chk("load_mode", Slave_mode, md);
    chk("load_mosi", MOSI, ph ? 1'b0 : b[7]);
    mosi_obs = 8'h00;
    e = 0;
    pleft = pause_len;
    while (e < 16) begin
      if (e == abort_at) return;
      if (e == pause_at && pleft > 0) begin
        enable = 1'b0;
        pleft--;
      end else begin
        enable = 1'b1;
        miso_drv = m[7 - e / 2];
        if (!ph && (e % 2) == 0) mosi_obs[7 - e / 2] = MOSI;
      end
      @(negedge clk);
      if (enable) e++;
      s  = ph ? e / 2 : (e + 1) / 2;
      bm = {b, m} << s;
      chk("sclk", sclk, md[1] ^ 1'(e % 2));
      chk("shift_reg", Master_SR, bm[15:8]);
      chk("done", Done, (e == 16) ? 16'h0001 : 16'h0000);
      chk("chip_selects", {Slave_I, Slave_II, Slave_III}, cs_exp(sel, enable && e < 16));
      if (ph && enable && (e % 2) == 1) mosi_obs[7 - (e - 1) / 2] = MOSI;
    end
    enable = 1'b1;
    @(negedge clk);
    chk("done_hold", Done, 16'h0001);
    chk("sclk_rest", sclk, md[1]);
    chk("sr_hold", Master_SR, m);
    chk("cs_after_done", {Slave_I, Slave_II, Slave_III}, 16'h0007);
    enable = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; enable = 1'b0; Mode = 2'd0; Select = 2'd0; inload = 8'h00;
    #1;
    chk_reset_vals("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_xfer(2'd0, 8'hE9, 8'h00, 1'b1, 2'd1, -1, 0, -1);
    run_xfer(2'd1, 8'h99, 8'h00, 1'b1, 2'd2, -1, 0, -1);
    run_xfer(2'd2, 8'hC9, 8'h00, 1'b1, 2'd3, -1, 0, -1);
    run_xfer(2'd3, 8'hF0, 8'h00, 1'b1, 2'd1, -1, 0, -1);
    run_xfer(2'd0, 8'hFF, 8'h00, 1'b0, 2'd1, -1, 0, -1);
    run_xfer(2'd0, 8'hA5, 8'h3C, 1'b0, 2'd2, 6, 5, -1);
    run_xfer(2'd3, 8'h5A, 8'hC3, 1'b0, 2'd0, 7, 5, -1);

    run_xfer(2'd1, 8'h81, 8'h7E, 1'b0, 2'd3, -1, 0, 7);
    run_xfer(2'd2, 8'h6D, 8'h00, 1'b1, 2'd3, -1, 0, -1);

    run_xfer(2'd3, 8'hB7, 8'h44, 1'b0, 2'd1, -1, 0, 9);
    reset = 1'b0; enable = 1'b0; load = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("post_reset");

    for (int i = 0; i < 20; i++) begin
      run_xfer(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               2'($urandom), $urandom_range(0, 15), $urandom_range(0, 3), -1);
    end

    @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

8-bit SPI master with selectable SPI mode (0–3) and three active-low slave selects. It parallel-loads a byte, then serially exchanges it MSB-first with the addressed slave, shifting MISO into the same shift register. It raises `Done` after 8 bits. It sits between a local controller (load/enable/select) and up to three SPI slave blocks, and forwards the active mode to them.

## Interface
- `DATA_W`, default 8: shift-register width. Only 8 is required.
- `clk` input 1: system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: synchronous parallel load of `inload`. Latches `Mode`.
- `Mode` input 2: SPI mode. Bit1 = CPOL, bit0 = CPHA.
- `MISO` input 1: serial data from the slave.
- `Select` input 2: slave address. 01 = I, 10 = II, 11 = III, 00 = none.
- `enable` input 1: run or continue the transfer. Low pauses it.
- `inload` input 8: byte to transmit.
- `sclk` output 1: SPI serial clock.
- `Slave_mode` output 2: latched mode, forwarded to the slaves.
- `Done` output 1: transfer complete (level).
- `MOSI` output 1: serial data to the slave.
- `Slave_I`, `Slave_II`, `Slave_III` output 1 each: active-low chip selects.
- `Master_SR` output 8: shift-register contents.

## Operation
- Reset (async, low):
  - `Master_SR`=0, `MOSI`=0, `sclk`=0, `Done`=0, `Slave_mode`=0, edge counter=0.
  - All chip selects = 1.
- Load. Has priority over `enable` and aborts any transfer in progress.
  - `Master_SR`←`inload`, `Slave_mode`←`Mode`, counter←0, `Done`←0.
  - `sclk`←CPOL of the new mode.
  - CPHA=1 only: `MOSI`←0.
- Transfer. Each cycle with `enable`=1, `Done`=0 and `load`=0:
  - `sclk` toggles and the counter increments.
  - Even counts (0, 2, …) are leading edges; odd counts are trailing edges.
- CPHA=0:
  - `MOSI` = `Master_SR[7]` (combinational).
  - Leading edge: `Master_SR`←{`Master_SR[6:0]`, `MISO`}.
  - Trailing edge: no data action.
- CPHA=1:
  - Leading edge: `MOSI`←`Master_SR[7]` (registered).
  - Trailing edge: `Master_SR`←{`Master_SR[6:0]`, `MISO`}.
- Completion: after 16 edges (8 bits), `Done`=1 and `sclk` rests at CPOL. `Done` holds until the next load or reset.
- Pause: `enable`=0 freezes `sclk`, the counter, `Master_SR` and `MOSI`.
- Chip selects:
  - The selected one is 0 while `enable`=1 and `Done`=0; all others are 1.
  - `Select`=00 asserts none, but the transfer still runs.
  - `Select` is decoded combinationally.
- Loopback (`MOSI` tied to `MISO`): after `Done`, `Master_SR` equals the loaded byte in all four modes.
- `Mode` changes after load have no effect until the next load.

## Timing
- Load is taken at rising edge N; the new values are visible after edge N.
- Bit period = 2 `clk` cycles. A full byte takes 16 enabled cycles.
- `Done` rises on the same clock edge as the 16th `sclk` toggle.
- Latency from first enabled cycle to `Done`: 16 cycles, plus any paused cycles.
- `load` and `enable` high in the same cycle: load wins; counting starts the next cycle.
- Reset mid-transfer: immediate return to reset values.
- Reset, or a load with a different CPOL, between transfers: `sclk` may step once.

## Structure
- Package `spi_pkg`:
  - Mode constants `SPI_MODE0..3`.
  - Helper functions `cpol(mode)` and `cpha(mode)`.
  - Select codes `SEL_NONE`, `SEL_I`, `SEL_II`, `SEL_III`.
- Sub-module `spi_clk_gen`:
  - Owns the `sclk` toggle and the 4-bit edge counter.
  - Emits `lead_edge`, `trail_edge` and `last_edge` strobes to the datapath.

## Test plan
- Mode 0, `inload`=8'b11101001, `Select`=01, loopback → `Done`=1 after 16 enabled cycles, `Master_SR`=11101001, `Slave_I` low only during transfer.
- Mode 1, `inload`=10011001 → `MOSI` valid after each leading edge (rising `sclk`), `Master_SR`=10011001 at `Done`.
- Mode 2 (11001001) and mode 3 (11110000) → `sclk` idles high before and after, `Master_SR` equals `inload`, `Slave_mode` = 2 and 3 respectively.
- `MISO` tied 0, `inload`=FF, mode 0 → `MOSI` sequence 1,1,1,1,1,1,1,1, `Master_SR`=00 at `Done`.
- `enable` dropped for 5 cycles after bit 3 → `sclk` and `Master_SR` frozen during the pause, `Done` delayed exactly 5 cycles.
- Assert `reset` low mid-transfer → all outputs return to reset values immediately. Load during a transfer → counter restarts, `Done`=0.
